// File: rtl/axi4_wr_arb2.sv
// Two-master AXI4 write-channel arbiter with one transaction in flight at a time.
// Define AXI4_WR_ARB_RR_EN for round-robin on simultaneous requests; default is fixed priority.
module axi4_wr_arb2 #(
    parameter int unsigned DSIZE  = 32,
    parameter int unsigned IDSIZE = 2,
    parameter int unsigned ASIZE  = 8,
    parameter int unsigned LSIZE  = 9
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic [1:0]          s_awvalid,
    output logic [1:0]          s_awready,
    input  logic [2*ASIZE-1:0]  s_awaddr,
    input  logic [2*IDSIZE-1:0] s_awid,
    input  logic [2*LSIZE-1:0]  s_awlen,
    input  logic [1:0]          s_wvalid,
    output logic [1:0]          s_wready,
    input  logic [2*DSIZE-1:0]  s_wdata,
    input  logic [1:0]          s_wlast,
    output logic [1:0]          s_bvalid,
    input  logic [1:0]          s_bready,
    output logic [IDSIZE-1:0]   s_bid,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [ASIZE-1:0]    m_awaddr,
    output logic [IDSIZE-1:0]   m_awid,
    output logic [LSIZE-1:0]    m_awlen,
    output logic                m_wvalid,
    input  logic                m_wready,
    output logic [DSIZE-1:0]    m_wdata,
    output logic                m_wlast,
    input  logic                m_bvalid,
    output logic                m_bready,
    input  logic [IDSIZE-1:0]   m_bid
);

    typedef enum logic [1:0] {StIdle, StAw, StW, StB} state_e;

    state_e state_q, state_d;
    logic   grant_q, grant_d;
    logic   pick;

    logic [ASIZE-1:0]  sel_awaddr;
    logic [IDSIZE-1:0] sel_awid;
    logic [LSIZE-1:0]  sel_awlen;
    logic [DSIZE-1:0]  sel_wdata;

    assign sel_awaddr = grant_q ? s_awaddr[2*ASIZE-1:ASIZE]   : s_awaddr[ASIZE-1:0];
    assign sel_awid   = grant_q ? s_awid[2*IDSIZE-1:IDSIZE]   : s_awid[IDSIZE-1:0];
    assign sel_awlen  = grant_q ? s_awlen[2*LSIZE-1:LSIZE]    : s_awlen[LSIZE-1:0];
    assign sel_wdata  = grant_q ? s_wdata[2*DSIZE-1:DSIZE]    : s_wdata[DSIZE-1:0];

`ifdef AXI4_WR_ARB_RR_EN
    logic last_q, last_d;

    // On a tie, hand the bus to whoever did not finish the previous transaction.
    assign pick = (&s_awvalid) ? ~last_q : s_awvalid[1];

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign pick = (&s_awvalid) ? 1'b0 : s_awvalid[1];
`endif

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
`ifdef AXI4_WR_ARB_RR_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (|s_awvalid) begin
                    grant_d = pick;
                    state_d = StAw;
                end
            end
            StAw: begin
                if (m_awready) state_d = StW;
            end
            StW: begin
                if (s_wvalid[grant_q] && m_wready && s_wlast[grant_q]) state_d = StB;
            end
            StB: begin
                if (m_bvalid && s_bready[grant_q]) begin
`ifdef AXI4_WR_ARB_RR_EN
                    last_d  = grant_q;
`endif
                    state_d = StIdle;
                end
            end
        endcase
    end

    // Everything not owned by the current phase is held at zero.
    always_comb begin
        s_awready = 2'b00;
        s_wready  = 2'b00;
        s_bvalid  = 2'b00;
        s_bid     = '0;
        m_awvalid = 1'b0;
        m_awaddr  = '0;
        m_awid    = '0;
        m_awlen   = '0;
        m_wvalid  = 1'b0;
        m_wdata   = '0;
        m_wlast   = 1'b0;
        m_bready  = 1'b0;
        unique case (state_q)
            StIdle: ;
            StAw: begin
                m_awvalid          = 1'b1;
                m_awaddr           = sel_awaddr;
                m_awid             = sel_awid;
                m_awlen            = sel_awlen;
                s_awready[grant_q] = m_awready;
            end
            StW: begin
                m_wvalid          = s_wvalid[grant_q];
                m_wdata           = sel_wdata;
                m_wlast           = s_wlast[grant_q];
                s_wready[grant_q] = m_wready;
            end
            StB: begin
                s_bvalid[grant_q] = m_bvalid;
                m_bready          = s_bready[grant_q];
                s_bid             = m_bid;
            end
        endcase
    end

endmodule

// File: tb/tb_axi4_wr_arb2.sv
// Randomized bench for axi4_wr_arb2 against a transaction-phase model, plus directed scenarios.
// Honours AXI4_WR_ARB_RR_EN the same way the design does.
module tb_axi4_wr_arb2;

    localparam int DSIZE  = 32;
    localparam int IDSIZE = 2;
    localparam int ASIZE  = 8;
    localparam int LSIZE  = 9;
`ifdef AXI4_WR_ARB_RR_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    logic                clock;
    logic                rst_n;
    logic [1:0]          s_awvalid, s_awready;
    logic [2*ASIZE-1:0]  s_awaddr;
    logic [2*IDSIZE-1:0] s_awid;
    logic [2*LSIZE-1:0]  s_awlen;
    logic [1:0]          s_wvalid, s_wready;
    logic [2*DSIZE-1:0]  s_wdata;
    logic [1:0]          s_wlast;
    logic [1:0]          s_bvalid, s_bready;
    logic [IDSIZE-1:0]   s_bid;
    logic                m_awvalid, m_awready;
    logic [ASIZE-1:0]    m_awaddr;
    logic [IDSIZE-1:0]   m_awid;
    logic [LSIZE-1:0]    m_awlen;
    logic                m_wvalid, m_wready;
    logic [DSIZE-1:0]    m_wdata;
    logic                m_wlast;
    logic                m_bvalid, m_bready;
    logic [IDSIZE-1:0]   m_bid;

    axi4_wr_arb2 #(.DSIZE(DSIZE), .IDSIZE(IDSIZE), .ASIZE(ASIZE), .LSIZE(LSIZE)) dut (
        .clock(clock), .rst_n(rst_n),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
        .s_awlen(s_awlen), .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
        .s_wlast(s_wlast), .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
        .m_awlen(m_awlen), .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
        .m_wlast(m_wlast), .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: owner of the bus (-1 when free) and which channel phases have completed.
    int owner    = -1;
    bit aw_done  = 1'b0;
    bit w_done   = 1'b0;
    bit last_m   = 1'b1;
    bit model_ok = 1'b0;

    always @(posedge clock) begin
        if (!rst_n) begin
            owner    <= -1;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            last_m   <= 1'b1;
            model_ok <= 1'b1;
        end else if (owner < 0) begin
            if (s_awvalid == 2'b11) owner <= (RrEn && !last_m) ? 1 : 0;
            else if (s_awvalid[0])  owner <= 0;
            else if (s_awvalid[1])  owner <= 1;
        end else if (!aw_done) begin
            if (m_awready) aw_done <= 1'b1;
        end else if (!w_done) begin
            if (s_wvalid[owner] && m_wready && s_wlast[owner]) w_done <= 1'b1;
        end else if (m_bvalid && s_bready[owner]) begin
            last_m  <= (owner == 1);
            owner   <= -1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end
    end

    task automatic compare_outputs();
        logic [1:0] e_awready = 2'b00, e_wready = 2'b00, e_bvalid = 2'b00;
        logic [IDSIZE-1:0] e_bid = '0, e_awid = '0;
        logic e_awvalid = 1'b0, e_wvalid = 1'b0, e_wlast = 1'b0, e_bready = 1'b0;
        logic [ASIZE-1:0] e_awaddr = '0;
        logic [LSIZE-1:0] e_awlen = '0;
        logic [DSIZE-1:0] e_wdata = '0;
        if (owner >= 0 && !aw_done) begin
            e_awvalid        = 1'b1;
            e_awaddr         = s_awaddr[owner*ASIZE +: ASIZE];
            e_awid           = s_awid[owner*IDSIZE +: IDSIZE];
            e_awlen          = s_awlen[owner*LSIZE +: LSIZE];
            e_awready[owner] = m_awready;
        end else if (owner >= 0 && !w_done) begin
            e_wvalid        = s_wvalid[owner];
            e_wdata         = s_wdata[owner*DSIZE +: DSIZE];
            e_wlast         = s_wlast[owner];
            e_wready[owner] = m_wready;
        end else if (owner >= 0) begin
            e_bvalid[owner] = m_bvalid;
            e_bready        = s_bready[owner];
            e_bid           = m_bid;
        end
        check("s_awready", s_awready, e_awready);
        check("s_wready", s_wready, e_wready);
        check("s_bvalid", s_bvalid, e_bvalid);
        check("s_bid", s_bid, e_bid);
        check("m_awvalid", m_awvalid, e_awvalid);
        check("m_awaddr", m_awaddr, e_awaddr);
        check("m_awid", m_awid, e_awid);
        check("m_awlen", m_awlen, e_awlen);
        check("m_wvalid", m_wvalid, e_wvalid);
        check("m_wdata", m_wdata, e_wdata);
        check("m_wlast", m_wlast, e_wlast);
        check("m_bready", m_bready, e_bready);
    endtask

    always @(negedge clock) if (model_ok) compare_outputs();

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        s_awvalid = 2'b00; s_awaddr = '0; s_awid = '0; s_awlen = '0;
        s_wvalid = 2'b00; s_wdata = '0; s_wlast = 2'b00; s_bready = 2'b00;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bid = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Runs one full write; master i uses address 0x10+0x10*i and ID i so the grant is visible.
    task automatic txn(input logic [1:0] req, input int beats, input bit toggle,
                       output int g, output int nfwd, output int nlast);
        int beat = 0;
        g = -1; nfwd = 0; nlast = 0;
        s_awvalid = req;
        s_awaddr  = {8'h20, 8'h10};
        s_awid    = {2'd1, 2'd0};
        s_awlen   = {9'(beats - 1), 9'(beats - 1)};
        m_awready = 1'b1;
        for (int c = 0; c < 4 && g < 0; c++) begin
            #3;
            if (m_awvalid) begin
                g = int'(m_awid);
                check("aw_addr_of_grant", m_awaddr, (g == 1) ? 8'h20 : 8'h10);
                check("aw_len", m_awlen, beats - 1);
            end
            step();
        end
        if (g < 0) begin
            check("aw_timeout", 1, 0);
            return;
        end
        m_awready = 1'b0;
        s_bready  = 2'b11;
        for (int c = 0; c < 40 && beat < beats; c++) begin
            s_wvalid = 2'b01 << g;
            s_wdata  = '0;
            s_wdata[g*DSIZE +: DSIZE] = DSIZE'(32'hA0 + beat + g * 256);
            s_wlast  = (beat == beats - 1) ? (2'b01 << g) : 2'b00;
            m_wready = toggle ? (c % 2 == 0) : 1'b1;
            #3;
            check("no_b_before_wlast", m_bready, 0);
            if (m_wvalid && m_wready) begin
                check("beat_data", m_wdata, 32'hA0 + beat + g * 256);
                nfwd++;
                if (m_wlast) nlast++;
                beat++;
            end
            step();
        end
        if (beat < beats) check("w_timeout", 1, 0);
        s_wvalid = 2'b00; s_wlast = 2'b00; m_wready = 1'b0;
        m_bvalid = 1'b1; m_bid = IDSIZE'(g + 2); s_bready = 2'b01 << g;
        #3;
        check("b_valid_routed", s_bvalid, 2'b01 << g);
        check("b_id", s_bid, g + 2);
        step();
        m_bvalid = 1'b0; s_bready = 2'b00;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, nf, nl;
        idle_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        // Reset state: idle, all outputs low even with slave-side inputs active.
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1;
        #3;
        check("reset_outputs_zero", |{s_awready, s_wready, s_bvalid, s_bid, m_awvalid, m_bready}, 0);
        step();
        idle_inputs();

        // Master 0 alone, four beats.
        txn(2'b01, 4, 1'b0, g, nf, nl);
        check("m0_alone_grant", g, 0);
        check("m0_alone_beats", nf, 4);
        check("m0_alone_wlast", nl, 1);
        idle_inputs();
        step();

        // Continuous simultaneous requests, single-beat bursts.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            txn(2'b11, 1, 1'b0, g, nf, nl);
            check("grant_seq", g, RrEn ? (i % 2) : 0);
        end
        idle_inputs();
        step();

        // Master 1 offers data before its address.
        m_wready = 1'b1; s_wvalid = 2'b10; s_wlast = 2'b10; s_wdata = {32'hBEEF, 32'h0};
        for (int i = 0; i < 3; i++) begin
            #3;
            check("early_w_stall", s_wready, 2'b00);
            step();
        end
        s_awvalid = 2'b10; s_awaddr = {8'h20, 8'h00}; s_awid = {2'd1, 2'd0};
        #3; check("early_w_idle", s_wready, 2'b00);
        step();
        #3; check("early_w_aw_wait", s_wready, 2'b00);
        check("early_w_awvalid", m_awvalid, 1);
        step();
        m_awready = 1'b1;
        #3; check("early_w_aw_hs", s_wready, 2'b00);
        step();
        s_awvalid = 2'b00; m_awready = 1'b0;
        #3; check("early_w_released", s_wready, 2'b10);
        check("early_w_data", m_wdata, 32'hBEEF);
        step();
        s_wvalid = 2'b00; s_wlast = 2'b00;
        m_bvalid = 1'b1; s_bready = 2'b10;
        step();
        idle_inputs();
        step();

        // Eight beats with m_wready toggling.
        txn(2'b01, 8, 1'b1, g, nf, nl);
        check("toggle_beats", nf, 8);
        check("toggle_wlast", nl, 1);
        idle_inputs();
        step();

        // Reset while master 1 is in its data phase.
        s_awvalid = 2'b10; m_awready = 1'b1;
        step();
        step();
        s_awvalid = 2'b00; m_awready = 1'b0; m_wready = 1'b0; s_wvalid = 2'b10;
        #3; check("mid_w_active", m_wvalid, 1);
        step();
        rst_n = 1'b0; s_awvalid = 2'b11; m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1;
        s_bready = 2'b11; s_wlast = 2'b11;
        step();
        rst_n = 1'b1;
        #3;
        check("post_reset_zero", |{s_awready, s_wready, s_bvalid, s_bid, m_awvalid, m_awaddr,
                                   m_awid, m_awlen, m_wvalid, m_wdata, m_wlast, m_bready}, 0);
        step();
        #3;
        check("post_reset_grant0", m_awid, 0);
        check("post_reset_awvalid", m_awvalid, 1);
        step();
        do_reset();

        // Randomized traffic, with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rst_n     = ($urandom_range(0, 59) != 0);
            s_awvalid = 2'($urandom_range(0, 3));
            s_awaddr  = (2 * ASIZE)'($urandom);
            s_awid    = (2 * IDSIZE)'($urandom);
            s_awlen   = (2 * LSIZE)'($urandom);
            s_wvalid  = 2'($urandom_range(0, 3));
            s_wdata   = {$urandom, $urandom};
            s_wlast   = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
            s_bready  = 2'($urandom_range(0, 3));
            m_awready = 1'($urandom_range(0, 1));
            m_wready  = 1'($urandom_range(0, 1));
            m_bvalid  = 1'($urandom_range(0, 1));
            m_bid     = IDSIZE'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
